dot_operand_sequencer: RTL and testbench

Upstream feeder for the half-precision dot-product unit (myFloatDot). It buffers up to DEPTH operand pairs written by a host. On `start_44` it clears the dot unit's accumulator, then presents each pair on the dot unit's inputs for a fixed hold window. After the final pair it waits for the pipeline to drain, captures the accumulated result and pulses `done_44`.

---
 rtl/dot_seq_pkg.sv | 18 +
 rtl/dot_pair_buf.sv | 26 ++
 rtl/dot_operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dot_operand_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot-product operand sequencer.
package dot_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] FP16_ZERO  = 16'h0000;
  localparam int          REG_SIZE_D = 16;
  localparam int          DEPTH_D    = 8;
  localparam int          HOLD_D     = 10;
  localparam int          DRAIN_D    = 10;

endpackage

// File: rtl/dot_pair_buf.sv
// Operand-pair register file: one write port, one asynchronous read port.
module dot_pair_buf #(
  parameter int REG_SIZE = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [REG_SIZE-1:0] i_wr_a,
  input  logic [REG_SIZE-1:0] i_wr_b,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [REG_SIZE-1:0] o_rd_a,
  output logic [REG_SIZE-1:0] o_rd_b
);

  // Contents survive reset; the sequencer's count decides what is valid.
  logic [DEPTH-1:0][2*REG_SIZE-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= {i_wr_a, i_wr_b};
  end

  assign {o_rd_a, o_rd_b} = r_mem[i_rd_addr];

endmodule

// File: rtl/dot_operand_sequencer.sv
// Buffers operand pairs and streams them into the dot-product unit, one pair
// per HOLD window, then drains the pipeline and captures the result.
module dot_operand_sequencer
  import dot_seq_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int ADDR_W   = 3,
  parameter int HOLD     = HOLD_D,
  parameter int DRAIN    = DRAIN_D
) (
  input  logic                clk_44,
  input  logic                reset_44,
  input  logic                wr_en_44,
  input  logic [REG_SIZE-1:0] wr_a_44,
  input  logic [REG_SIZE-1:0] wr_b_44,
  output logic                wr_full_44,
  output logic [ADDR_W:0]     count_44,
  input  logic                start_44,
  output logic                busy_44,
  output logic [REG_SIZE-1:0] op_a_44,
  output logic [REG_SIZE-1:0] op_b_44,
  output logic                dot_rst_n_44,
  input  logic [REG_SIZE-1:0] dot_res_44,
  output logic [REG_SIZE-1:0] result_44,
  output logic                done_44
);

  localparam int CW = ADDR_W + 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam int DW = $clog2(DRAIN + 1);
  localparam logic [REG_SIZE-1:0] ZERO = REG_SIZE'(FP16_ZERO);

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [HW-1:0]       r_hold;
  logic [DW-1:0]       r_drain;
  logic [REG_SIZE-1:0] r_op_a, r_op_b, r_result;
  logic                r_busy, r_done, r_dot_rst_n;

  logic                w_full, w_wr_acc, w_last;
  logic [CW-1:0]       w_cnt_nxt;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [REG_SIZE-1:0] w_rd_a, w_rd_b;

  assign w_full    = (r_count == CW'(DEPTH)) | r_busy;
  assign w_wr_acc  = wr_en_44 & ~w_full & (r_state == ST_IDLE);
  assign w_cnt_nxt = r_count + CW'(w_wr_acc);
  // Read port looks one entry ahead so the next pair is ready at the window edge.
  assign w_rd_addr = (r_state == ST_ISSUE) ? r_rd_ptr + ADDR_W'(1) : '0;
  assign w_last    = ({1'b0, r_rd_ptr} + CW'(1)) == r_count;

  dot_pair_buf #(
    .REG_SIZE(REG_SIZE),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_buf (
    .clk      (clk_44),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr),
    .i_wr_a   (wr_a_44),
    .i_wr_b   (wr_b_44),
    .i_rd_addr(w_rd_addr),
    .o_rd_a   (w_rd_a),
    .o_rd_b   (w_rd_b)
  );

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_hold      <= '0;
      r_drain     <= '0;
      r_op_a      <= ZERO;
      r_op_b      <= ZERO;
      r_result    <= ZERO;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dot_rst_n <= 1'b1;
    end else begin
      r_done      <= 1'b0;
      r_dot_rst_n <= 1'b1;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        r_count  <= w_cnt_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          // A same-cycle write is already folded into w_cnt_nxt.
          if (start_44) begin
            r_busy <= 1'b1;
            if (w_cnt_nxt != '0) begin
              r_state     <= ST_CLEAR;
              r_dot_rst_n <= 1'b0;
              r_op_a      <= ZERO;
              r_op_b      <= ZERO;
              r_rd_ptr    <= '0;
            end else begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= ZERO;
            end
          end
        end
        ST_CLEAR: begin
          r_state <= ST_ISSUE;
          r_op_a  <= w_rd_a;
          r_op_b  <= w_rd_b;
          r_hold  <= '0;
        end
        ST_ISSUE: begin
          if (r_hold == HW'(HOLD - 1)) begin
            r_hold <= '0;
            if (w_last) begin
              r_state <= ST_DRAIN;
              r_op_a  <= ZERO;
              r_op_b  <= ZERO;
              r_drain <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
              r_op_a   <= w_rd_a;
              r_op_b   <= w_rd_b;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == DW'(DRAIN - 1)) begin
            r_result <= dot_res_44;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        ST_DONE: begin
          r_busy   <= 1'b0;
          r_count  <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_full_44   = w_full;
  assign count_44     = r_count;
  assign busy_44      = r_busy;
  assign op_a_44      = r_op_a;
  assign op_b_44      = r_op_b;
  assign dot_rst_n_44 = r_dot_rst_n;
  assign result_44    = r_result;
  assign done_44      = r_done;

endmodule

// File: tb/tb_dot_operand_sequencer.sv
// Self-checking bench: a stand-in accumulator plays the dot unit; expected
// schedules and results come from the queued pairs and the timing rules.
module tb_dot_operand_sequencer;

  localparam int H   = 10;
  localparam int D   = 10;
  localparam int DEP = 8;

  logic        clk_44 = 1'b0;
  logic        reset_44 = 1'b0;
  logic        wr_en_44 = 1'b0;
  logic [15:0] wr_a_44 = '0, wr_b_44 = '0;
  logic        start_44 = 1'b0;
  logic        wr_full_44, busy_44, dot_rst_n_44, done_44;
  logic [3:0]  count_44;
  logic [15:0] op_a_44, op_b_44, dot_res_44, result_44;

  dot_operand_sequencer dut (
    .clk_44      (clk_44),
    .reset_44    (reset_44),
    .wr_en_44    (wr_en_44),
    .wr_a_44     (wr_a_44),
    .wr_b_44     (wr_b_44),
    .wr_full_44  (wr_full_44),
    .count_44    (count_44),
    .start_44    (start_44),
    .busy_44     (busy_44),
    .op_a_44     (op_a_44),
    .op_b_44     (op_b_44),
    .dot_rst_n_44(dot_rst_n_44),
    .dot_res_44  (dot_res_44),
    .result_44   (result_44),
    .done_44     (done_44)
  );

  always #5 clk_44 = ~clk_44;

  // Stand-in dot unit: every cycle adds a*b + (a^b) (mod 2^16); zero operands add nothing.
  logic [15:0] acc;
  wire         dot_rg = dot_rst_n_44 & reset_44;
  always_ff @(posedge clk_44 or negedge dot_rg) begin
    if (!dot_rg) acc <= '0;
    else         acc <= acc + 16'(op_a_44 * op_b_44) + (op_a_44 ^ op_b_44);
  end
  assign dot_res_44 = acc;

  int tests = 0, fails = 0;
  logic [15:0] qa[$], qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each pair sits on the inputs for H cycles, so it contributes H times.
  function automatic logic [15:0] model_res();
    logic [15:0] s = '0;
    logic [31:0] p;
    foreach (qa[i]) begin
      p = qa[i] * qb[i];
      s = s + p[15:0] + (qa[i] ^ qb[i]);
    end
    return 16'(s * H);
  endfunction

  task automatic mwrite(input logic [15:0] a, input logic [15:0] b);
    wr_en_44 = 1'b1; wr_a_44 = a; wr_b_44 = b;
    if (qa.size() < DEP) begin qa.push_back(a); qb.push_back(b); end
    @(negedge clk_44);
    wr_en_44 = 1'b0;
  endtask

  task automatic run(input bit with_wr, input logic [15:0] a, input logic [15:0] b,
                     input bit disturb);
    int n, len, idx;
    logic [15:0] er, ea, eb;
    if (with_wr) begin
      wr_en_44 = 1'b1; wr_a_44 = a; wr_b_44 = b;
      if (qa.size() < DEP) begin qa.push_back(a); qb.push_back(b); end
    end
    start_44 = 1'b1;
    @(negedge clk_44);
    start_44 = 1'b0; wr_en_44 = 1'b0;
    n   = qa.size();
    len = (n > 0) ? 2 + n * H + D : 1;
    er  = model_res();
    for (int c = 1; c <= len; c++) begin
      ea = '0; eb = '0;
      if (n > 0 && c >= 2 && c <= 1 + n * H) begin
        idx = (c - 2) / H;
        ea = qa[idx]; eb = qb[idx];
      end
      chk("sched", {24'h0, busy_44, dot_rst_n_44, op_a_44, op_b_44, done_44, count_44, wr_full_44},
          {24'h0, 1'b1, !(n > 0 && c == 1), ea, eb, c == len, 4'(n), 1'b1});
      if (c == len) chk("result", {48'h0, result_44}, {48'h0, er});
      if (disturb && (c == 4 || c == H + 3)) begin
        start_44 = 1'b1; wr_en_44 = 1'b1; wr_a_44 = 16'($urandom); wr_b_44 = 16'($urandom);
      end else begin
        start_44 = 1'b0; wr_en_44 = 1'b0;
      end
      @(negedge clk_44);
    end
    start_44 = 1'b0; wr_en_44 = 1'b0;
    chk("post_run", {busy_44, done_44, count_44, wr_full_44, op_a_44, op_b_44, result_44},
        {1'b0, 1'b0, 4'd0, 1'b0, 16'h0, 16'h0, er});
    qa.delete(); qb.delete();
  endtask

  typedef struct {
    bit          wr;
    bit          st;
    logic [15:0] a, b;
    logic [3:0]  cnt;
    bit          full, busy, done;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0] = '{0, 1, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1, 1'b1};  // empty start
    tbl[1] = '{0, 0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      tbl[2+i] = '{1, 0, 16'($urandom), 16'($urandom), (i < DEP) ? 4'(i + 1) : 4'(DEP),
                   (i >= DEP - 1), 1'b0, 1'b0};

    repeat (3) @(negedge clk_44);
    chk("reset", {op_a_44, op_b_44, result_44, 4'(count_44), 4'({busy_44, done_44, wr_full_44, dot_rst_n_44})},
        {16'h0, 16'h0, 16'h0, 4'h0, 4'b0001});
    reset_44 = 1'b1;
    @(negedge clk_44);

    // Empty start, then fill past DEPTH: the 9th write must be dropped.
    foreach (tbl[i]) begin
      wr_en_44 = tbl[i].wr; start_44 = tbl[i].st; wr_a_44 = tbl[i].a; wr_b_44 = tbl[i].b;
      if (tbl[i].wr && qa.size() < DEP) begin qa.push_back(tbl[i].a); qb.push_back(tbl[i].b); end
      @(negedge clk_44);
      wr_en_44 = 1'b0; start_44 = 1'b0;
      chk("tbl", {24'h0, count_44, wr_full_44, busy_44, done_44, op_a_44, op_b_44},
          {24'h0, tbl[i].cnt, tbl[i].full, tbl[i].busy, tbl[i].done, 32'h0});
    end
    run(0, 16'h0, 16'h0, 0);

    mwrite(16'h3400, 16'h3000);
    run(0, 16'h0, 16'h0, 0);
    run(0, 16'h0, 16'h0, 0);  // empty start after a nonzero result

    mwrite(16'h3400, 16'h3000);
    mwrite(16'h3800, 16'h3800);
    run(0, 16'h0, 16'h0, 1);  // start/write pulses mid-run are ignored

    mwrite(16'h1234, 16'h0567);
    run(1, 16'h4321, 16'h0abc, 0);  // write and start in the same cycle

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, DEP);
      for (int k = 0; k < n; k++) mwrite(16'($urandom), 16'($urandom));
      run(0, 16'h0, 16'h0, 0);
    end

    // Reset in the middle of ISSUE
    mwrite(16'h2222, 16'h3333);
    mwrite(16'h4444, 16'h5555);
    start_44 = 1'b1;
    @(negedge clk_44);
    start_44 = 1'b0;
    repeat (6) @(negedge clk_44);
    reset_44 = 1'b0;
    #1;
    chk("rst_mid", {op_a_44, op_b_44, result_44, 4'(count_44), 4'({busy_44, done_44, wr_full_44, dot_rst_n_44})},
        {16'h0, 16'h0, 16'h0, 4'h0, 4'b0001});
    qa.delete(); qb.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_44);
      chk("rst_hold", {62'h0, done_44, busy_44}, 64'h0);
    end
    reset_44 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_44);
      chk("rst_nodone", {58'h0, done_44, busy_44, count_44}, 64'h0);
    end
    mwrite(16'h3400, 16'h3000);
    run(0, 16'h0, 16'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
